zsram_access_arbiter: RTL and testbench
=======================================

Name: zsram_access_arbiter

Overview:
- Controller for a row-organised array of zero-second RAM cells.
- Arbitrates between two requesters (A and B) with round-robin priority.
- Sequences each access as setup, then strobe, then recover. Each row has its own WriteEdge and ReadEdge strobe, and all rows share the InputData/OutputData buses.
- Provides the only legal way for system logic to drive cell strobes.

Parameters:
- WIDTH, 8: bits per word; one cell per bit in each row.
- DEPTH, 16: number of rows (words).
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= DEPTH.
- STROBE_CYCLES, 2: cycles a strobe is held high; legal range 1..15.

Ports:
- Crystal50Mhz1  input  1  system clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ReqA  input  1  requester A access request.
- WeA  input  1  A: 1 = write, 0 = read.
- AddrA  input  ADDR_W  A row address.
- WdataA  input  WIDTH  A write data.
- AckA  output  1  A completion pulse.
- RdataA  output  WIDTH  A read data; valid when AckA=1.
- ReqB, WeB, AddrB, WdataB, AckB, RdataB: same as the A ports, for requester B.
- WriteEdge  output  DEPTH  one-hot per-row write strobe to the cells.
- ReadEdge  output  DEPTH  one-hot per-row read strobe to the cells.
- InputData  output  WIDTH  shared write data bus to the cells.
- OutputData  input  WIDTH  shared read data bus from the selected row.
- Busy  output  1  high in any state other than IDLE.
- AddrError  output  1  one-cycle pulse when an access has address >= DEPTH.

Behaviour:
- Reset (async assert) forces all of the following immediately, with no clock required:
  - FSM=IDLE.
  - WriteEdge=0, ReadEdge=0, InputData=0.
  - AckA=AckB=0, RdataA=RdataB=0.
  - Busy=0, AddrError=0.
  - Priority pointer set so that A wins the first contention.
- Reset mid-access aborts the access: no Ack is given and no further strobe is issued. Deassertion is synchronised in the usual way; first arbitration happens on the first clock after release.
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one of ReqA/ReqB high: grant it.
  - Both high: grant the requester not granted last. After reset, A wins.
  - On grant: latch We, Addr and Wdata of the winner plus the winner id, update the priority pointer, go to SETUP.
- SETUP (1 cycle):
  - InputData = latched Wdata for writes, 0 for reads.
  - Strobes stay 0.
  - Load the strobe counter with STROBE_CYCLES-1.
- STROBE (STROBE_CYCLES cycles):
  - Write: WriteEdge[addr]=1, all other bits 0.
  - Read: ReadEdge[addr]=1, all other bits 0.
  - InputData stays stable throughout.
  - Read data: OutputData is sampled into the winner's Rdata register on the last STROBE cycle (counter==0).
  - Never more than one strobe bit is high, and WriteEdge and ReadEdge are never high together.
- RECOVER (1 cycle):
  - All strobes 0; InputData held.
  - The winner's Ack=1 for exactly this cycle; the loser's Ack stays 0.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle t gives Ack at t+2+STROBE_CYCLES. Back-to-back throughput is one access per 3+STROBE_CYCLES cycles.
- Requester handshake:
  - Hold Req, We, Addr and Wdata until Ack.
  - Changes after grant are ignored, because the inputs are latched at grant.
  - Req still high in the cycle after Ack is treated as a new request.
- Rdata register:
  - Updated only by a completed read.
  - Holds its value across later writes and across accesses by the other requester.
- Out-of-range address (Addr >= DEPTH):
  - Full state sequence with identical timing, but no strobe bit is asserted.
  - Read returns Rdata=0.
  - AddrError pulses in the same cycle as Ack.
- InputData returns to 0 when IDLE is entered.
- Busy = (state != IDLE).

Test Plan:
- Reset, then ReqA write Addr=3, Wdata=0xA5 (STROBE_CYCLES=2) -> AckA 4 cycles after request sampled. WriteEdge=0x0008 for exactly 2 cycles, InputData=0xA5 from SETUP through RECOVER. ReadEdge stays 0.
- ReqB read Addr=3 with OutputData model returning 0xA5 while ReadEdge[3]=1 -> RdataB=0xA5 with AckB. RdataA unchanged. AckA stays 0.
- ReqA and ReqB both held high continuously after reset -> grant order A, B, A, B. Each Ack is a single-cycle pulse. Strobes are never high in SETUP or RECOVER.
- ReqA read Addr=20 with DEPTH=16 -> no strobe bit set, AckA with RdataA=0, AddrError pulse coincident with AckA.
- Assert Reset during the first STROBE cycle of a write to Addr=5 -> WriteEdge drops to 0 asynchronously (before the next clock edge), no AckA, Busy=0. After release, a pending ReqA is re-granted and completes normally.
- Sweep STROBE_CYCLES=1 and 15 with a write then a read to Addr=DEPTH-1 -> strobe width equals STROBE_CYCLES, read data matches, Ack at t+3 and t+17 respectively.

Source files
------------

// File: rtl/zsram_access_arbiter_if.sv
// Handshake and cell-array bundle for the zero-second RAM access arbiter.
// The master side is the system (requesters plus the cell read bus); the slave side is the arbiter.
interface zsram_access_arbiter_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
);

    logic              ReqA;
    logic              WeA;
    logic [ADDR_W-1:0] AddrA;
    logic [WIDTH-1:0]  WdataA;
    logic              AckA;
    logic [WIDTH-1:0]  RdataA;

    logic              ReqB;
    logic              WeB;
    logic [ADDR_W-1:0] AddrB;
    logic [WIDTH-1:0]  WdataB;
    logic              AckB;
    logic [WIDTH-1:0]  RdataB;

    logic [DEPTH-1:0]  WriteEdge;
    logic [DEPTH-1:0]  ReadEdge;
    logic [WIDTH-1:0]  InputData;
    logic [WIDTH-1:0]  OutputData;
    logic              Busy;
    logic              AddrError;

    modport master (
        output ReqA, WeA, AddrA, WdataA,
        output ReqB, WeB, AddrB, WdataB,
        output OutputData,
        input  AckA, RdataA, AckB, RdataB,
        input  WriteEdge, ReadEdge, InputData, Busy, AddrError
    );

    modport slave (
        input  ReqA, WeA, AddrA, WdataA,
        input  ReqB, WeB, AddrB, WdataB,
        input  OutputData,
        output AckA, RdataA, AckB, RdataB,
        output WriteEdge, ReadEdge, InputData, Busy, AddrError
    );

endinterface

// File: rtl/zsram_access_arbiter.sv
// Round-robin arbiter and setup/strobe/recover sequencer for a row-organised zero-second RAM array.
// It is the only block allowed to drive the per-row WriteEdge/ReadEdge strobes.
module zsram_access_arbiter #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  Crystal50Mhz1,
    input  logic                  Reset,
    zsram_access_arbiter_if.slave bus
);

    localparam int CNT_W = 4;
    localparam bit ADDR_SPARE = (2 ** ADDR_W) > DEPTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } stateT;

    stateT             state;
    stateT             stateNext;

    logic              grantValid;
    logic              grantB;
    logic              grantWe;
    logic [ADDR_W-1:0] grantAddr;
    logic [WIDTH-1:0]  grantWdata;
    logic              grantAddrOk;

    logic              curWe;
    logic              curIsB;
    logic              curAddrOk;
    logic [ADDR_W-1:0] curAddr;
    logic [WIDTH-1:0]  curWdata;

    logic              lastGrantB;
    logic [CNT_W-1:0]  strobeCount;
    logic              strobeLast;
    logic [DEPTH-1:0]  rowSel;
    logic [WIDTH-1:0]  rdSample;
    logic [WIDTH-1:0]  rdataA;
    logic [WIDTH-1:0]  rdataB;

    // Round-robin pick: on contention the requester not served last wins; reset leaves B as "last" so A goes first.
    always_comb begin
        grantValid = 1'b0;
        grantB     = 1'b0;
        if (bus.ReqA && bus.ReqB) begin
            grantValid = 1'b1;
            grantB     = ~lastGrantB;
        end else if (bus.ReqA) begin
            grantValid = 1'b1;
        end else if (bus.ReqB) begin
            grantValid = 1'b1;
            grantB     = 1'b1;
        end
    end

    assign grantWe    = grantB ? bus.WeB    : bus.WeA;
    assign grantAddr  = grantB ? bus.AddrB  : bus.AddrA;
    assign grantWdata = grantB ? bus.WdataB : bus.WdataA;

    // Only an address space wider than the row count can hold out-of-range addresses.
    generate
        if (ADDR_SPARE) begin : gRangeCheck
            assign grantAddrOk = (grantAddr < ADDR_W'(DEPTH));
        end else begin : gNoRangeCheck
            assign grantAddrOk = 1'b1;
        end
    endgenerate

    assign strobeLast = (strobeCount == '0);
    assign rowSel     = curAddrOk ? (DEPTH'(1) << curAddr) : '0;
    assign rdSample   = curAddrOk ? bus.OutputData : '0;

    // State register; an asynchronous reset aborts any access in flight.
    always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Access context is captured at grant so requester changes afterwards cannot disturb the sequence.
    always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
        if (Reset) begin
            curWe       <= 1'b0;
            curIsB      <= 1'b0;
            curAddrOk   <= 1'b0;
            curAddr     <= '0;
            curWdata    <= '0;
            lastGrantB  <= 1'b1;
            strobeCount <= '0;
            rdataA      <= '0;
            rdataB      <= '0;
        end else begin
            if (state == IDLE && grantValid) begin
                curWe      <= grantWe;
                curIsB     <= grantB;
                curAddrOk  <= grantAddrOk;
                curAddr    <= grantAddr;
                curWdata   <= grantWdata;
                lastGrantB <= grantB;
            end
            if (state == SETUP) begin
                strobeCount <= CNT_W'(STROBE_CYCLES - 1);
            end else if (state == STROBE && !strobeLast) begin
                strobeCount <= strobeCount - 1'b1;
            end
            if (state == STROBE && strobeLast && !curWe) begin
                if (curIsB) begin
                    rdataB <= rdSample;
                end else begin
                    rdataA <= rdSample;
                end
            end
        end
    end

    // Next state and all cell/requester outputs are decoded from the state and the latched access.
    always_comb begin
        stateNext     = state;
        bus.WriteEdge = '0;
        bus.ReadEdge  = '0;
        bus.InputData = '0;
        bus.AckA      = 1'b0;
        bus.AckB      = 1'b0;
        bus.AddrError = 1'b0;
        bus.Busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grantValid) begin
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                bus.InputData = curWe ? curWdata : '0;
                stateNext     = STROBE;
            end
            STROBE: begin
                bus.InputData = curWe ? curWdata : '0;
                if (curWe) begin
                    bus.WriteEdge = rowSel;
                end else begin
                    bus.ReadEdge = rowSel;
                end
                if (strobeLast) begin
                    stateNext = RECOVER;
                end
            end
            RECOVER: begin
                bus.InputData = curWe ? curWdata : '0;
                bus.AckA      = ~curIsB;
                bus.AckB      = curIsB;
                bus.AddrError = ~curAddrOk;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.RdataA = rdataA;
    assign bus.RdataB = rdataB;

endmodule

// File: tb/tb_zsram_access_arbiter.sv
// Bench for zsram_access_arbiter: a transaction-level model checks the main instance every cycle,
// while directed sequences pin latency, strobe width, arbitration order, reset abort and range errors.
module tb_zsram_access_arbiter;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;
    localparam int S_MAIN = 2;

    logic clk = 1'b0;
    logic Reset;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    zsram_access_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) busM ();
    zsram_access_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus1 ();
    zsram_access_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus15 ();

    zsram_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STROBE_CYCLES(S_MAIN)) dutMain (
        .Crystal50Mhz1(clk), .Reset(Reset), .bus(busM));
    zsram_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STROBE_CYCLES(1)) dutS1 (
        .Crystal50Mhz1(clk), .Reset(Reset), .bus(bus1));
    zsram_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STROBE_CYCLES(15)) dutS15 (
        .Crystal50Mhz1(clk), .Reset(Reset), .bus(bus15));

    // Zero-second cell arrays: a strobed row captures InputData, a read strobe puts the row on OutputData.
    logic [WIDTH-1:0] memM  [DEPTH] = '{default: 8'h00};
    logic [WIDTH-1:0] mem1  [DEPTH] = '{default: 8'h00};
    logic [WIDTH-1:0] mem15 [DEPTH] = '{default: 8'h00};

    always @(posedge clk) begin
        for (int r = 0; r < DEPTH; r++) begin
            if (busM.WriteEdge[r])  memM[r]  <= busM.InputData;
            if (bus1.WriteEdge[r])  mem1[r]  <= bus1.InputData;
            if (bus15.WriteEdge[r]) mem15[r] <= bus15.InputData;
        end
    end

    always_comb begin
        busM.OutputData  = '0;
        bus1.OutputData  = '0;
        bus15.OutputData = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (busM.ReadEdge[r])  busM.OutputData  = memM[r];
            if (bus1.ReadEdge[r])  bus1.OutputData  = mem1[r];
            if (bus15.ReadEdge[r]) bus15.OutputData = mem15[r];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic reqA, input logic weA, input logic [ADDR_W-1:0] addrA,
                                 input logic [WIDTH-1:0] wdataA, input logic reqB, input logic weB,
                                 input logic [ADDR_W-1:0] addrB, input logic [WIDTH-1:0] wdataB);
        busM.ReqA = reqA; busM.WeA = weA; busM.AddrA = addrA; busM.WdataA = wdataA;
        busM.ReqB = reqB; busM.WeB = weB; busM.AddrB = addrB; busM.WdataB = wdataB;
    endtask

    // Transaction model of the main instance: elapsed cycles since grant, 0 = setup, S_MAIN+1 = ack cycle.
    bit               mActive  = 1'b0;
    int               mElapsed = 0;
    bit               mWe      = 1'b0;
    bit               mIsB     = 1'b0;
    bit               mLastB   = 1'b1;
    logic [ADDR_W-1:0] mAddr   = '0;
    logic [WIDTH-1:0] mData    = '0;
    logic [WIDTH-1:0] mRdA     = '0;
    logic [WIDTH-1:0] mRdB     = '0;
    logic [WIDTH-1:0] mMem [DEPTH] = '{default: 8'h00};
    logic [DEPTH-1:0] expStrobe;
    bit               lastCycle;

    initial begin : compareProc
        forever begin
            @(negedge clk);
            if (Reset) begin
                mActive = 1'b0; mRdA = '0; mRdB = '0; mLastB = 1'b1;
            end
            expStrobe = (mActive && mElapsed >= 1 && mElapsed <= S_MAIN && mAddr < DEPTH)
                        ? (DEPTH'(1) << mAddr) : '0;
            lastCycle = mActive && (mElapsed == S_MAIN + 1);
            checkOutput("cycBusy", busM.Busy, mActive);
            checkOutput("cycWriteEdge", busM.WriteEdge, mWe ? expStrobe : '0);
            checkOutput("cycReadEdge", busM.ReadEdge, mWe ? '0 : expStrobe);
            checkOutput("cycInputData", busM.InputData, (mActive && mWe) ? mData : '0);
            checkOutput("cycAckA", busM.AckA, lastCycle && !mIsB);
            checkOutput("cycAckB", busM.AckB, lastCycle && mIsB);
            checkOutput("cycAddrError", busM.AddrError, lastCycle && (mAddr >= DEPTH));
            checkOutput("cycRdataA", busM.RdataA, mRdA);
            checkOutput("cycRdataB", busM.RdataB, mRdB);
            if (!Reset) begin
                if (mActive) begin
                    if (lastCycle) begin
                        mActive = 1'b0;
                        if (mWe && mAddr < DEPTH) mMem[mAddr] = mData;
                    end else begin
                        if (mElapsed == S_MAIN && !mWe) begin
                            if (mIsB) mRdB = (mAddr < DEPTH) ? mMem[mAddr] : '0;
                            else      mRdA = (mAddr < DEPTH) ? mMem[mAddr] : '0;
                        end
                        mElapsed++;
                    end
                end else if (busM.ReqA || busM.ReqB) begin
                    mIsB     = (busM.ReqA && busM.ReqB) ? !mLastB : busM.ReqB;
                    mLastB   = mIsB;
                    mWe      = mIsB ? busM.WeB : busM.WeA;
                    mAddr    = mIsB ? busM.AddrB : busM.AddrA;
                    mData    = mIsB ? busM.WdataB : busM.WdataA;
                    mActive  = 1'b1;
                    mElapsed = 0;
                end
            end
        end
    end

    task automatic waitAck(input bit isB, output int lat, output int strobes, output logic err,
                           output logic [WIDTH-1:0] rdata, output int otherAcks);
        lat = -1; strobes = 0; err = 1'b0; rdata = '0; otherAcks = 0;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (busM.WriteEdge != '0 || busM.ReadEdge != '0) strobes++;
            if (isB ? busM.AckA : busM.AckB) otherAcks++;
            if (isB ? busM.AckB : busM.AckA) begin
                lat   = n;
                err   = busM.AddrError;
                rdata = isB ? busM.RdataB : busM.RdataA;
            end
        end
    endtask

    task automatic runAccess(input bit isB, input bit we, input logic [ADDR_W-1:0] addr,
                             input logic [WIDTH-1:0] data, output int lat, output int strobes,
                             output logic err, output logic [WIDTH-1:0] rdata, output int otherAcks);
        if (isB) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, we, addr, data);
        else     applyStimulus(1'b1, we, addr, data, 1'b0, 1'b0, '0, '0);
        waitAck(isB, lat, strobes, err, rdata, otherAcks);
        stepEdge();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic runSweep(input int which, input bit we, input logic [WIDTH-1:0] data,
                            output int lat, output int width, output logic [WIDTH-1:0] rdata);
        lat = -1; width = 0; rdata = '0;
        if (which == 1) begin
            bus1.ReqA = 1'b1; bus1.WeA = we; bus1.AddrA = ADDR_W'(DEPTH - 1); bus1.WdataA = data;
        end else begin
            bus15.ReqA = 1'b1; bus15.WeA = we; bus15.AddrA = ADDR_W'(DEPTH - 1); bus15.WdataA = data;
        end
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (which == 1) begin
                if ((we ? bus1.WriteEdge : bus1.ReadEdge) == 16'h8000) width++;
                if (bus1.AckA) begin lat = n; rdata = bus1.RdataA; end
            end else begin
                if ((we ? bus15.WriteEdge : bus15.ReadEdge) == 16'h8000) width++;
                if (bus15.AckA) begin lat = n; rdata = bus15.RdataA; end
            end
        end
        stepEdge();
        if (which == 1) bus1.ReqA = 1'b0;
        else            bus15.ReqA = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int               lat;
    int               strobes;
    int               other;
    int               acks;
    int               doubles;
    logic             err;
    logic             prevAck;
    logic [WIDTH-1:0] rdata;
    logic [3:0]       order;

    initial begin : stimulus
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        bus1.ReqA = 0; bus1.WeA = 0; bus1.AddrA = '0; bus1.WdataA = '0;
        bus1.ReqB = 0; bus1.WeB = 0; bus1.AddrB = '0; bus1.WdataB = '0;
        bus15.ReqA = 0; bus15.WeA = 0; bus15.AddrA = '0; bus15.WdataA = '0;
        bus15.ReqB = 0; bus15.WeB = 0; bus15.AddrB = '0; bus15.WdataB = '0;
        stepEdge();
        stepEdge();
        checkOutput("resetBusy", busM.Busy, 1'b0);
        checkOutput("resetWriteEdge", busM.WriteEdge, 16'h0000);
        checkOutput("resetAckA", busM.AckA, 1'b0);
        checkOutput("resetRdataA", busM.RdataA, 8'h00);
        Reset = 1'b0;

        $display("[TB] write A addr 3");
        runAccess(1'b0, 1'b1, 5'd3, 8'hA5, lat, strobes, err, rdata, other);
        checkOutput("wrLatency", lat, 4);
        checkOutput("wrStrobeCycles", strobes, 2);
        checkOutput("wrAddrError", err, 1'b0);

        $display("[TB] read B addr 3");
        runAccess(1'b1, 1'b0, 5'd3, 8'h00, lat, strobes, err, rdata, other);
        checkOutput("rdLatency", lat, 4);
        checkOutput("rdRdataB", rdata, 8'hA5);
        checkOutput("rdOtherAck", other, 0);
        checkOutput("rdRdataAHeld", busM.RdataA, 8'h00);

        $display("[TB] contention after reset");
        Reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b1, 5'd7, 8'h3C);
        stepEdge();
        stepEdge();
        Reset = 1'b0;
        acks = 0; doubles = 0; strobes = 0; prevAck = 1'b0; order = '0;
        for (int n = 0; n < 60 && acks < 4; n++) begin
            @(negedge clk);
            if (busM.WriteEdge != '0 || busM.ReadEdge != '0) strobes++;
            if ((busM.AckA || busM.AckB) && prevAck) doubles++;
            if (busM.AckA || busM.AckB) begin
                order[acks] = busM.AckB;
                acks++;
            end
            prevAck = busM.AckA || busM.AckB;
        end
        stepEdge();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("rrAckCount", acks, 4);
        checkOutput("rrOrder", order, 4'b1010);
        checkOutput("rrDoublePulse", doubles, 0);
        checkOutput("rrStrobeTotal", strobes, 8);

        $display("[TB] out-of-range read A addr 20");
        runAccess(1'b0, 1'b0, 5'd20, 8'h00, lat, strobes, err, rdata, other);
        checkOutput("oorLatency", lat, 4);
        checkOutput("oorStrobes", strobes, 0);
        checkOutput("oorAddrError", err, 1'b1);
        checkOutput("oorRdataA", rdata, 8'h00);

        $display("[TB] reset during strobe of write A addr 5");
        applyStimulus(1'b1, 1'b1, 5'd5, 8'h5A, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("abortStrobeBefore", busM.WriteEdge, 16'h0020);
        Reset = 1'b1;
        #1;
        checkOutput("abortStrobeAsync", busM.WriteEdge, 16'h0000);
        checkOutput("abortBusy", busM.Busy, 1'b0);
        checkOutput("abortAckA", busM.AckA, 1'b0);
        stepEdge();
        Reset = 1'b0;
        waitAck(1'b0, lat, strobes, err, rdata, other);
        stepEdge();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("regrantLatency", lat, 4);
        checkOutput("regrantStrobes", strobes, 2);

        $display("[TB] strobe width sweep on last row");
        runSweep(1, 1'b1, 8'hC3, lat, strobes, rdata);
        checkOutput("s1WrLatency", lat, 3);
        checkOutput("s1WrWidth", strobes, 1);
        runSweep(1, 1'b0, 8'h00, lat, strobes, rdata);
        checkOutput("s1RdLatency", lat, 3);
        checkOutput("s1RdWidth", strobes, 1);
        checkOutput("s1RdData", rdata, 8'hC3);
        runSweep(15, 1'b1, 8'h96, lat, strobes, rdata);
        checkOutput("s15WrLatency", lat, 17);
        checkOutput("s15WrWidth", strobes, 15);
        runSweep(15, 1'b0, 8'h00, lat, strobes, rdata);
        checkOutput("s15RdLatency", lat, 17);
        checkOutput("s15RdWidth", strobes, 15);
        checkOutput("s15RdData", rdata, 8'h96);

        stepEdge();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
